// File: rtl/mem_req_resp_port.sv
// mem_req_resp_port
//   DATA_W x 2**ADDR_W memory with a direct write port and a valid/ready read
//   port. Accepted reads capture the addressed word on the accept edge and
//   queue it, with its address, in a 2-entry in-order response buffer.
//   The array zeroes itself after reset and on a clear command.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data       write port (honoured only when idle)
//   clr_start, busy               clear command (idle only) / clear in progress
//   rd_req_valid/ready/addr       read request channel
//   rd_resp_valid/ready/data/addr read response channel (head of buffer)
module mem_req_resp_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    output logic              busy,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,
    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,
    output logic [ADDR_W-1:0] rd_resp_addr
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] buf_data_q [2];
    logic [DATA_W-1:0] buf_data_d [2];
    logic [ADDR_W-1:0] buf_addr_q [2];
    logic [ADDR_W-1:0] buf_addr_d [2];
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        count_q, count_d;

    logic              push;
    logic              pop;

    // State register (plus buffer bookkeeping)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            ptr_q      <= '0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= '0;
            buf_data_q <= '{default: '0};
            buf_addr_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            buf_data_q <= buf_data_d;
            buf_addr_q <= buf_addr_d;
        end
    end

    // Array has no reset of its own; the CLEAR sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + (ADDR_W + 1)'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Output logic: registered-state functions only
    always_comb begin
        busy          = (state_q == CLEAR);
        rd_req_ready  = (state_q == IDLE) && (count_q != 2'd2);
        rd_resp_valid = (count_q != 2'd0);
        rd_resp_data  = buf_data_q[head_q];
        rd_resp_addr  = buf_addr_q[head_q];
    end

    // Write-port mux: the clear sweep owns the array while clearing
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_q == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q[ADDR_W-1:0];
            mem_wdata = '0;
        end else if (wr_en) begin
            mem_we = 1'b1;
        end
    end

    // The word is captured on the accept edge, so a same-edge write is not seen.
    assign rd_word = mem[rd_req_addr];

    // Response buffer
    always_comb begin
        push       = rd_req_valid && rd_req_ready;
        pop        = rd_resp_valid && rd_resp_ready;
        buf_data_d = buf_data_q;
        buf_addr_d = buf_addr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (push) begin
            buf_data_d[tail_q] = rd_word;
            buf_addr_d[tail_q] = rd_req_addr;
            tail_d             = ~tail_q;
        end
        if (pop) begin
            head_d = ~head_q;
        end
        count_d = count_q + 2'(push) - 2'(pop);
    end

endmodule

// File: tb/tb_mem_req_resp_port.sv
// Bench for mem_req_resp_port: a queue-based reference model runs alongside
// the design; each scenario task drives stimulus and compares inline.
module tb_mem_req_resp_port;

    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr_start;
    logic       busy;
    logic       rd_req_valid;
    logic       rd_req_ready;
    logic [7:0] rd_req_addr;
    logic       rd_resp_valid;
    logic       rd_resp_ready;
    logic [7:0] rd_resp_data;
    logic [7:0] rd_resp_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [7:0] ref_mem [DEPTH];
    logic [7:0] q_data [$];
    logic [7:0] q_addr [$];
    int         clear_left = DEPTH;

    mem_req_resp_port #(
        .DATA_W(8),
        .ADDR_W(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .clr_start    (clr_start),
        .busy         (busy),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_resp_valid(rd_resp_valid),
        .rd_resp_ready(rd_resp_ready),
        .rd_resp_data (rd_resp_data),
        .rd_resp_addr (rd_resp_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic bit m_busy();
        return clear_left > 0;
    endfunction

    function automatic bit m_ready();
        return (clear_left == 0) && (q_data.size() < 2);
    endfunction

    function automatic bit m_valid();
        return q_data.size() > 0;
    endfunction

    task automatic model_wipe();
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    endtask

    task automatic drive_idle();
        wr_en        = 1'b0;
        wr_addr      = 8'h00;
        wr_data      = 8'h00;
        clr_start    = 1'b0;
        rd_req_valid = 1'b0;
        rd_req_addr  = 8'h00;
    endtask

    // Apply current inputs across one clock edge and advance the model.
    task automatic tick();
        bit acc;
        bit pp;
        acc = rd_req_valid && m_ready();
        pp  = m_valid() && rd_resp_ready;
        @(posedge clk);
        if (rst) begin
            clear_left = DEPTH;
            q_data.delete();
            q_addr.delete();
            model_wipe();
        end else begin
            if (pp) begin
                void'(q_data.pop_front());
                void'(q_addr.pop_front());
            end
            if (acc) begin
                q_data.push_back(ref_mem[rd_req_addr]);
                q_addr.push_back(rd_req_addr);
            end
            if (clear_left > 0) begin
                clear_left--;
            end else begin
                if (wr_en) ref_mem[wr_addr] = wr_data;
                if (clr_start) begin
                    clear_left = DEPTH;
                    model_wipe();
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] addrs [3];
        addrs = '{8'h00, 8'h7F, 8'hFF};
        drive_idle();
        rd_resp_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || rd_req_ready !== 1'b0 || rd_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/ready/valid got %b%b%b expected 100", busy, rd_req_ready, rd_resp_valid);
        end
        n_checks++;
        if (rd_resp_data !== 8'h00 || rd_resp_addr !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_head: data/addr got %h/%h expected 00/00", rd_resp_data, rd_resp_addr);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (busy !== 1'b1 || rd_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_clear_cycle %0d: busy/ready got %b%b expected 10", i, busy, rd_req_ready);
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || rd_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_clear_end: busy/ready got %b%b expected 01", busy, rd_req_ready);
        end
        rd_resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = addrs[i];
            tick();
            n_checks++;
            if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'h00 || rd_resp_addr !== addrs[i]) begin
                n_fail++;
                $display("FAIL reset_read: valid/data/addr got %b/%h/%h expected 1/00/%h",
                         rd_resp_valid, rd_resp_data, rd_resp_addr, addrs[i]);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_write_read();
        drive_idle();
        rd_resp_ready = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 8'h10;
        wr_data = 8'hA5;
        tick();
        wr_en        = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = 8'h10;
        tick();
        rd_req_valid = 1'b0;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'hA5 || rd_resp_addr !== 8'h10) begin
            n_fail++;
            $display("FAIL write_read: valid/data/addr got %b/%h/%h expected 1/a5/10",
                     rd_resp_valid, rd_resp_data, rd_resp_addr);
        end
        tick();
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_read_hold: valid/data got %b/%h expected 1/a5", rd_resp_valid, rd_resp_data);
        end
        rd_resp_ready = 1'b1;
        tick();
        n_checks++;
        if (rd_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_read_pop: valid got %b expected 0", rd_resp_valid);
        end
    endtask

    task automatic test_collision();
        drive_idle();
        rd_resp_ready = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 8'h20;
        wr_data = 8'h11;
        tick();
        wr_data      = 8'h22;
        rd_req_valid = 1'b1;
        rd_req_addr  = 8'h20;
        tick();
        wr_en = 1'b0;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'h11 || rd_resp_addr !== 8'h20) begin
            n_fail++;
            $display("FAIL collision_old: valid/data/addr got %b/%h/%h expected 1/11/20",
                     rd_resp_valid, rd_resp_data, rd_resp_addr);
        end
        tick();
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'h22) begin
            n_fail++;
            $display("FAIL collision_new: valid/data got %b/%h expected 1/22", rd_resp_valid, rd_resp_data);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] d [4];
        drive_idle();
        rd_resp_ready = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            d[a]    = 8'($urandom);
            wr_en   = 1'b1;
            wr_addr = 8'(a);
            wr_data = d[a];
            tick();
        end
        wr_en = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = 8'(a);
            n_checks++;
            if (rd_req_ready !== (a < 3)) begin
                n_fail++;
                $display("FAIL bp_ready req %0d: got %b expected %b", a, rd_req_ready, (a < 3));
            end
            tick();
        end
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (rd_req_ready !== 1'b0 || rd_resp_valid !== 1'b1 ||
                rd_resp_addr !== 8'h01 || rd_resp_data !== d[1]) begin
                n_fail++;
                $display("FAIL bp_stall: ready/valid/addr/data got %b/%b/%h/%h expected 0/1/01/%h",
                         rd_req_ready, rd_resp_valid, rd_resp_addr, rd_resp_data, d[1]);
            end
            tick();
        end
        rd_resp_ready = 1'b1;
        tick();
        n_checks++;
        if (rd_resp_addr !== 8'h02 || rd_resp_data !== d[2] || rd_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: addr/data/ready got %h/%h/%b expected 02/%h/1",
                     rd_resp_addr, rd_resp_data, rd_req_ready, d[2]);
        end
        tick();
        rd_req_valid = 1'b0;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_resp_addr !== 8'h03 || rd_resp_data !== d[3]) begin
            n_fail++;
            $display("FAIL bp_third: valid/addr/data got %b/%h/%h expected 1/03/%h",
                     rd_resp_valid, rd_resp_addr, rd_resp_data, d[3]);
        end
        tick();
        n_checks++;
        if (rd_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: valid got %b expected 0", rd_resp_valid);
        end
    endtask

    task automatic test_streaming();
        drive_idle();
        rd_resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = 8'(i);
            n_checks++;
            if (rd_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready %0d: got %b expected 1", i, rd_req_ready);
            end
            tick();
            n_checks++;
            if (rd_resp_valid !== 1'b1 || rd_resp_addr !== 8'(i) || rd_resp_data !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL stream_resp %0d: valid/addr/data got %b/%h/%h expected 1/%h/%h",
                         i, rd_resp_valid, rd_resp_addr, rd_resp_data, 8'(i), ref_mem[i]);
            end
        end
        drive_idle();
        tick();
        n_checks++;
        if (rd_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: valid got %b expected 0", rd_resp_valid);
        end
    endtask

    task automatic test_random();
        drive_idle();
        for (int c = 0; c < 800; c++) begin
            wr_en         = ($urandom_range(0, 2) == 0);
            wr_addr       = 8'($urandom_range(0, 31));
            wr_data       = 8'($urandom);
            clr_start     = ($urandom_range(0, 299) == 0);
            rd_req_valid  = ($urandom_range(0, 1) == 1);
            rd_req_addr   = 8'($urandom_range(0, 31));
            rd_resp_ready = ($urandom_range(0, 9) < 7);
            n_checks++;
            if (busy !== m_busy() || rd_req_ready !== m_ready() || rd_resp_valid !== m_valid()) begin
                n_fail++;
                $display("FAIL rand_ctrl cycle %0d: busy/ready/valid got %b%b%b expected %b%b%b",
                         c, busy, rd_req_ready, rd_resp_valid, m_busy(), m_ready(), m_valid());
            end
            if (m_valid()) begin
                n_checks++;
                if (rd_resp_data !== q_data[0] || rd_resp_addr !== q_addr[0]) begin
                    n_fail++;
                    $display("FAIL rand_head cycle %0d: data/addr got %h/%h expected %h/%h",
                             c, rd_resp_data, rd_resp_addr, q_data[0], q_addr[0]);
                end
            end
            tick();
        end
        drive_idle();
        rd_resp_ready = 1'b1;
        while (busy === 1'b1 && clear_left > 0) tick();
        tick();
        tick();
    endtask

    task automatic test_clear_mid();
        int n;
        drive_idle();
        rd_resp_ready = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 8'h10;
        wr_data = 8'hA5;
        tick();
        wr_en        = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr  = 8'h10;
        tick();
        rd_req_valid = 1'b0;
        clr_start    = 1'b1;
        tick();
        clr_start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || rd_resp_valid !== 1'b1 || rd_resp_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL clear_buffered: busy/valid/data got %b/%b/%h expected 1/1/a5",
                     busy, rd_resp_valid, rd_resp_data);
        end
        rd_resp_ready = 1'b1;
        tick();
        n = 1;
        n_checks++;
        if (rd_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_drain: valid got %b expected 0", rd_resp_valid);
        end
        while (busy === 1'b1 && n < 400) begin
            clr_start = (n == 50);
            tick();
            n++;
        end
        clr_start = 1'b0;
        n_checks++;
        if (n !== DEPTH) begin
            n_fail++;
            $display("FAIL clear_length: busy cycles got %0d expected %0d", n, DEPTH);
        end
        rd_req_valid = 1'b1;
        rd_req_addr  = 8'h10;
        tick();
        rd_req_valid = 1'b0;
        n_checks++;
        if (rd_resp_valid !== 1'b1 || rd_resp_data !== 8'h00 || rd_resp_addr !== 8'h10) begin
            n_fail++;
            $display("FAIL clear_zeroed: valid/data/addr got %b/%h/%h expected 1/00/10",
                     rd_resp_valid, rd_resp_data, rd_resp_addr);
        end
        tick();
    endtask

    task automatic test_rst_mid_clear();
        int n;
        drive_idle();
        rd_resp_ready = 1'b0;
        rd_req_valid  = 1'b1;
        rd_req_addr   = 8'h33;
        tick();
        rd_req_valid = 1'b0;
        clr_start    = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        n_checks++;
        if (busy !== 1'b1 || rd_resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: busy/valid got %b%b expected 11", busy, rd_resp_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || rd_resp_valid !== 1'b0 || rd_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_post: busy/valid/ready got %b%b%b expected 100",
                     busy, rd_resp_valid, rd_req_ready);
        end
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            tick();
            n++;
        end
        n_checks++;
        if (n !== DEPTH) begin
            n_fail++;
            $display("FAIL rst_mid_length: busy cycles got %0d expected %0d", n, DEPTH);
        end
        n_checks++;
        if (rd_req_ready !== 1'b1 || rd_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_end: ready/valid got %b%b expected 10", rd_req_ready, rd_resp_valid);
        end
    endtask

    initial begin
        rst           = 1'b1;
        rd_resp_ready = 1'b0;
        drive_idle();
        model_wipe();
        test_reset();
        test_write_read();
        test_collision();
        test_backpressure();
        test_streaming();
        test_random();
        test_clear_mid();
        test_rst_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_resp_port.md
# mem_req_resp_port

Single-port-write, handshaked-read memory stage that owns a `DATA_W x DEPTH` array. It accepts read requests over a valid/ready channel and performs a registered (synchronous) array read. Results are delivered through a 2-entry response buffer that absorbs consumer backpressure. It also self-clears the array after reset or on command, and sits between request producers (address generators) and data consumers.

## Interface
- `DATA_W`, 8, word width in bits
- `ADDR_W`, 8, address width; `DEPTH` = 2**`ADDR_W` entries, index 0..DEPTH-1
- `clk`  in  1  sole clock, all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `wr_en`  in  1  write strobe
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `clr_start`  in  1  request full-array clear (honoured in IDLE only)
- `busy`  out  1  high while clearing
- `rd_req_valid`  in  1  read request valid
- `rd_req_ready`  out  1  stage can accept a request this cycle
- `rd_req_addr`  in  ADDR_W  read address
- `rd_resp_valid`  out  1  head response valid
- `rd_resp_ready`  in  1  consumer accepts head response
- `rd_resp_data`  out  DATA_W  head response data
- `rd_resp_addr`  out  ADDR_W  address the head response was read from

## Operation
- FSM states: CLEAR, IDLE.
- Reset: state=CLEAR, clear pointer=0, response buffer emptied (count=0).
  - Array contents are not reset directly; CLEAR zeroes them.
- CLEAR:
  - each cycle writes 0 to `mem[ptr]` and increments `ptr`
  - after the cycle writing DEPTH-1, moves to IDLE; CLEAR lasts exactly DEPTH cycles
  - `busy`=1; `rd_req_ready`=0; `wr_en` ignored
  - buffered responses still drain to the consumer
- IDLE:
  - `clr_start`=1 → CLEAR with `ptr`=0 on the next edge
  - `clr_start` in CLEAR is ignored; it does not restart the clear
  - `wr_en`=1 writes `wr_data` to `mem[wr_addr]`
- Read accept: `rd_req_valid && rd_req_ready`.
  - On that edge, `mem[rd_req_addr]` and `rd_req_addr` are pushed into the response buffer.
  - The read is sampled at the accept edge; a later write does not alter a buffered response.
- Read/write collision (same address, same edge): read returns OLD contents (read-before-write).
- `rd_req_ready` = (state==IDLE) && (count<2).
  - Registered-state function only; no combinational path from `rd_resp_ready`.
- Response buffer: 2-entry FIFO, in-order.
  - `rd_resp_valid` = (count>0); head data/addr always presented.
  - Pop on `rd_resp_valid && rd_resp_ready`.
  - Push+pop on the same edge: count unchanged, order preserved.
- `rd_resp_data`/`rd_resp_addr` hold stable while `rd_resp_valid && !rd_resp_ready`. They are don't-care when count=0 and are not required to be zero.
- Width rules: addresses are unsigned and index directly with no wrap logic. `ptr` is ADDR_W+1 bits so DEPTH is detectable.

## Timing
- Outputs after reset: `busy`=1, `rd_req_ready`=0, `rd_resp_valid`=0, `rd_resp_data`=0, `rd_resp_addr`=0.
- First `rd_req_ready`=1 occurs DEPTH+1 cycles after the reset edge (DEPTH clear cycles, then IDLE).
- Read latency:
  - accept at edge k → `rd_resp_valid`=1 in the cycle after edge k, when the buffer was empty
  - otherwise the response queues behind older entries
- Throughput: 1 request/cycle sustained while `rd_resp_ready`=1 (count stays ≤1).
- Backpressure: with `rd_resp_ready`=0, at most 2 requests are accepted, then `rd_req_ready`=0. The first pop re-raises ready on the next cycle.
- Write visibility: a write on edge k is visible to a read accepted on edge k+1 or later.
- `rst` mid-CLEAR or mid-stream: aborts everything, flushes the buffer, and restarts the clear at `ptr`=0.

## Test plan
- Reset, DEPTH=256:
  - `busy`=1 for exactly 256 cycles and `rd_req_ready`=0 throughout
  - then read addr 0x00, 0x7F, 0xFF → each response data=0x00 with matching `rd_resp_addr`
- Write/read: write 0xA5 to addr 0x10, next cycle read 0x10 → `rd_resp_valid` the following cycle, data=0xA5, addr=0x10.
- Collision:
  - mem[0x20]=0x11; on one edge write 0x22 to 0x20 and accept a read of 0x20 → response 0x11
  - a subsequent read of 0x20 → 0x22
- Backpressure: hold `rd_resp_ready`=0 and request 0x01, 0x02, 0x03.
  - only 2 are accepted; `rd_req_ready` drops
  - release → responses arrive in order 0x01, 0x02, then 0x03 is accepted
  - data stays stable while stalled
- Streaming: `rd_resp_ready`=1 with back-to-back requests for 0x00..0x0F → 16 responses on 16 consecutive cycles, no bubbles.
- Clear/reset mid-operation:
  - `clr_start` with 1 response buffered → response still delivered, `busy` high 256 cycles, previously written 0xA5 at 0x10 reads back 0x00
  - `rst` asserted at clear cycle 100 → clear restarts, `busy` high 256 further cycles, buffer empty
